// File: rtl/wwfa_pkg.sv
// Shared helpers and types for the wrapped-wavefront allocator.
package wwfa_pkg;

    localparam int MAX_PORTS = 16;
    localparam int MAX_IDX_W = 4;

    // Port index and one-hot port vector sized for the largest supported crossbar.
    typedef logic [MAX_IDX_W-1:0] port_idx_t;
    typedef logic [MAX_PORTS-1:0] port_vec_t;

    // Ceiling log2, valid for value >= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Modular difference (col - row) mod n: the diagonal that cell (row, col) sits on.
    function automatic int diag_idx(input int col, input int row, input int n);
        return (col - row + n) % n;
    endfunction

endpackage

// File: rtl/wwfa_cell.sv
// One allocator cell: grants when it requests and both its row and column are still free.
module wwfa_cell
    import wwfa_pkg::*;
(
    input  logic req_i,
    input  logic row_free_i,
    input  logic col_free_i,
    output logic gnt_o,
    output logic row_free_o,
    output logic col_free_o
);

    assign gnt_o      = req_i & row_free_i & col_free_i;
    assign row_free_o = row_free_i & ~gnt_o;
    assign col_free_o = col_free_i & ~gnt_o;

endmodule

// File: rtl/wwfa_alloc_n.sv
// N x N wrapped-wavefront crossbar allocator with locked connections,
// rotating priority diagonal and optional hold-time watchdog.
module wwfa_alloc_n
    import wwfa_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int ADDR_W   = 32,
    parameter int HOLD_MAX = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic [N_PORTS-1:0]                req_i,
    input  logic [N_PORTS*ADDR_W-1:0]         addr_i,
    input  logic [N_PORTS-1:0]                release_i,
    output logic [N_PORTS-1:0]                in_gnt_o,
    output logic [N_PORTS-1:0]                out_vld_o,
    output logic [N_PORTS*clog2(N_PORTS)-1:0] out_sel_o,
    output logic [N_PORTS-1:0]                timeout_o,
    output logic [clog2(N_PORTS)-1:0]         prio_diag_o
);

    localparam int IDX_W = clog2(N_PORTS);
    localparam int CNT_W = (HOLD_MAX > 0) ? clog2(HOLD_MAX + 1) : 1;

    logic [N_PORTS-1:0]       conn_q, conn_d;
    logic [N_PORTS-1:0]       busy_q, busy_d;
    logic [N_PORTS-1:0]       to_q, to_d;
    logic [N_PORTS*IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]         prio_q, prio_d;
    logic [CNT_W-1:0]         cnt_q [N_PORTS];
    logic [CNT_W-1:0]         cnt_d [N_PORTS];

    logic [IDX_W-1:0]         dest_s [N_PORTS];
    logic [N_PORTS-1:0]       new_gnt_s;
    logic [N_PORTS-1:0]       expire_s;
    logic [N_PORTS-1:0]       drop_s;
    logic [N_PORTS-1:0]       free_out_s;

    // Destination port is the top IDX_W bits of each input's address word.
    for (genvar i = 0; i < N_PORTS; i++) begin : g_dest
        assign dest_s[i] = addr_i[i*ADDR_W + ADDR_W - 1 -: IDX_W];
    end

    // Wavefront: step s evaluates diagonal (prio + s); row/column availability
    // ripples from step to step so earlier diagonals win conflicts.
    for (genvar s = 0; s < N_PORTS; s++) begin : g_step
        logic [IDX_W-1:0]   diag_s;
        logic [N_PORTS-1:0] row_in_s;       // indexed by input
        logic [N_PORTS-1:0] col_in_s;       // indexed by output
        logic [N_PORTS-1:0] row_out_s;      // indexed by input
        logic [N_PORTS-1:0] col_out_s;      // indexed by output
        logic [N_PORTS-1:0] cell_req_s;     // indexed by input
        logic [N_PORTS-1:0] cell_col_in_s;  // indexed by input
        logic [N_PORTS-1:0] cell_col_out_s; // indexed by input
        logic [N_PORTS-1:0] gnt_s;          // indexed by input
        logic [N_PORTS-1:0] gnt_acc_s;      // grants from steps 0..s

        assign diag_s = prio_q + IDX_W'(s);

        if (s == 0) begin : g_first
            assign row_in_s  = ~conn_q;
            assign col_in_s  = ~busy_q;
            assign gnt_acc_s = gnt_s;
        end else begin : g_next
            assign row_in_s  = g_step[s-1].row_out_s;
            assign col_in_s  = g_step[s-1].col_out_s;
            assign gnt_acc_s = g_step[s-1].gnt_acc_s | gnt_s;
        end

        for (genvar i = 0; i < N_PORTS; i++) begin : g_row
            logic [IDX_W-1:0] col_s;

            assign col_s = IDX_W'(i) + diag_s;
            assign cell_req_s[i] = enable_i & req_i[i] & ~conn_q[i] & ~busy_q[col_s]
                                   & (dest_s[i] == col_s);
            assign cell_col_in_s[i] = col_in_s[col_s];

            wwfa_cell u_cell (
                .req_i      (cell_req_s[i]),
                .row_free_i (row_in_s[i]),
                .col_free_i (cell_col_in_s[i]),
                .gnt_o      (gnt_s[i]),
                .row_free_o (row_out_s[i]),
                .col_free_o (cell_col_out_s[i])
            );

            // Output i on this diagonal is served by input (i - diag) mod N.
            assign col_out_s[i] = cell_col_out_s[IDX_W'(diag_idx(i, int'(diag_s), N_PORTS))];
        end
    end

    // Release and watchdog decisions for currently held connections.
    always_comb begin
        expire_s   = '0;
        drop_s     = '0;
        free_out_s = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            expire_s[i] = (HOLD_MAX > 0) && conn_q[i] && (cnt_q[i] == CNT_W'(HOLD_MAX))
                          && !release_i[i];
            drop_s[i]   = conn_q[i] & (release_i[i] | expire_s[i]);
        end
        for (int o = 0; o < N_PORTS; o++) begin
            free_out_s[o] = busy_q[o] & drop_s[sel_q[o*IDX_W +: IDX_W]];
        end
    end

    // Next-state: merge the wavefront result with releases and advance the diagonal.
    always_comb begin
        new_gnt_s = g_step[N_PORTS-1].gnt_acc_s;
        conn_d    = ~g_step[N_PORTS-1].row_out_s & ~drop_s;
        busy_d    = ~g_step[N_PORTS-1].col_out_s & ~free_out_s;
        to_d      = expire_s;
        prio_d    = (|new_gnt_s) ? (prio_q + IDX_W'(1)) : prio_q;
        sel_d     = sel_q;
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                sel_d[o*IDX_W +: IDX_W] = (new_gnt_s[i] && (dest_s[i] == IDX_W'(o)))
                                          ? IDX_W'(i) : sel_d[o*IDX_W +: IDX_W];
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (HOLD_MAX == 0) begin
                cnt_d[i] = '0;
            end else if (new_gnt_s[i]) begin
                cnt_d[i] = CNT_W'(1);
            end else if (drop_s[i]) begin
                cnt_d[i] = '0;
            end else if (conn_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with synchronous reset; reset drops connections without a timeout pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            conn_q <= '0;
            busy_q <= '0;
            to_q   <= '0;
            sel_q  <= '0;
            prio_q <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            conn_q <= conn_d;
            busy_q <= busy_d;
            to_q   <= to_d;
            sel_q  <= sel_d;
            prio_q <= prio_d;
            for (int i = 0; i < N_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_gnt_o    = conn_q;
    assign out_vld_o   = busy_q;
    assign out_sel_o   = sel_q;
    assign timeout_o   = to_q;
    assign prio_diag_o = prio_q;

endmodule

// File: tb/tb_wwfa_alloc_n.sv
// Directed + short random bench for wwfa_alloc_n (N=4, HOLD_MAX=8) with a scoreboard queue.
module tb_wwfa_alloc_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int HM = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    rel;
    logic [N-1:0]    in_gnt;
    logic [N-1:0]    out_vld;
    logic [N*IW-1:0] out_sel;
    logic [N-1:0]    timeout;
    logic [IW-1:0]   prio_diag;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] vld;
        logic [7:0] sel;
        logic [3:0] to;
        logic [1:0] prio;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model state
    bit m_conn [N];
    bit m_busy [N];
    int m_sel  [N];
    int m_dst  [N];
    int m_cnt  [N];
    bit m_to   [N];
    int m_prio;
    int cur_dst [N];

    always #5 clk = ~clk;

    wwfa_alloc_n #(.N_PORTS(N), .ADDR_W(AW), .HOLD_MAX(HM)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .req_i       (req),
        .addr_i      (addr),
        .release_i   (rel),
        .in_gnt_o    (in_gnt),
        .out_vld_o   (out_vld),
        .out_sel_o   (out_sel),
        .timeout_o   (timeout),
        .prio_diag_o (prio_diag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_conn[i] = 1'b0; m_busy[i] = 1'b0; m_sel[i] = 0;
            m_dst[i] = 0; m_cnt[i] = 0; m_to[i] = 1'b0;
        end
        m_prio = 0;
    endtask

    task automatic model_step(input bit rst, input bit en, input logic [3:0] rq, input logic [3:0] rl);
        bit g [N];
        int go [N];
        bit rowu [N];
        bit colu [N];
        bit any;
        int d, o;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            g[i] = 1'b0; go[i] = 0; rowu[i] = 1'b0; colu[i] = 1'b0;
        end
        // Grants are decided on the pre-edge state, diagonal by diagonal.
        if (en) begin
            for (int s = 0; s < N; s++) begin
                d = (m_prio + s) % N;
                for (int i = 0; i < N; i++) begin
                    o = (i + d) % N;
                    if (rq[i] && !m_conn[i] && !m_busy[o] && cur_dst[i] == o && !rowu[i] && !colu[o]) begin
                        g[i] = 1'b1; go[i] = o; rowu[i] = 1'b1; colu[o] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_to[i] = 1'b0;
            if (m_conn[i]) begin
                if (rl[i] || m_cnt[i] == HM) begin
                    m_to[i] = !rl[i];
                    m_conn[i] = 1'b0;
                    m_busy[m_dst[i]] = 1'b0;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                m_conn[i] = 1'b1; m_busy[go[i]] = 1'b1; m_sel[go[i]] = i;
                m_dst[i] = go[i]; m_cnt[i] = 1; any = 1'b1;
            end
        end
        if (any) m_prio = (m_prio + 1) % N;
    endtask

    // One clock: drive inputs, push the expected post-edge state, compare after the edge.
    task automatic cyc(input bit rst, input bit en, input logic [3:0] rq, input logic [3:0] rl);
        snap_t e;
        reset = rst; enable = en; req = rq; rel = rl;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = {2'(cur_dst[i]), 30'($urandom)};
        end
        model_step(rst, en, rq, rl);
        for (int i = 0; i < N; i++) begin
            e.gnt[i] = m_conn[i];
            e.vld[i] = m_busy[i];
            e.sel[i*IW +: IW] = 2'(m_sel[i]);
            e.to[i] = m_to[i];
        end
        e.prio = 2'(m_prio);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("in_gnt", 32'(in_gnt), 32'(e.gnt));
        check("out_vld", 32'(out_vld), 32'(e.vld));
        check("out_sel", 32'(out_sel), 32'(e.sel));
        check("timeout", 32'(timeout), 32'(e.to));
        check("prio_diag", 32'(prio_diag), 32'(e.prio));
    endtask

    int hi, tp, p_before;

    initial begin
        reset = 1'b1; enable = 1'b0; req = '0; rel = '0; addr = '0;
        model_reset();
        for (int i = 0; i < N; i++) cur_dst[i] = 2;

        // Reset held with all requests active
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 4'hF, 4'h0);
        check("rst_gnt", 32'(in_gnt), 32'd0);
        check("rst_prio", 32'(prio_diag), 32'd0);

        // Contention on output 2 from prio 0: input 2 wins
        cyc(1'b0, 1'b1, 4'hF, 4'h0);
        check("cont_gnt", 32'(in_gnt), 32'h4);
        check("cont_sel2", 32'(out_sel[2*IW +: IW]), 32'd2);
        check("cont_prio", 32'(prio_diag), 32'd1);
        cyc(1'b0, 1'b1, 4'hF, 4'h0);
        // Release input 2, then diagonal 1 hands output 2 to input 1
        cyc(1'b0, 1'b1, 4'hF, 4'h4);
        check("rel_gnt", 32'(in_gnt), 32'h0);
        cyc(1'b0, 1'b1, 4'hF, 4'h0);
        check("rot_gnt", 32'(in_gnt), 32'h2);
        check("rot_sel2", 32'(out_sel[2*IW +: IW]), 32'd1);
        check("rot_prio", 32'(prio_diag), 32'd2);
        cyc(1'b0, 1'b1, 4'h0, 4'h2);
        cyc(1'b0, 1'b1, 4'h0, 4'h0);

        // Permutation 0->1, 1->2, 2->3, 3->0 granted in one cycle
        cur_dst[0] = 1; cur_dst[1] = 2; cur_dst[2] = 3; cur_dst[3] = 0;
        cyc(1'b0, 1'b1, 4'hF, 4'h0);
        check("perm_vld", 32'(out_vld), 32'hF);
        check("perm_sel", 32'(out_sel), 32'(8'b10_01_00_11));
        check("perm_prio", 32'(prio_diag), 32'd3);
        cyc(1'b0, 1'b1, 4'h0, 4'hF);
        cyc(1'b0, 1'b1, 4'h0, 4'h0);

        // Watchdog: input 0 -> output 3 never released
        cur_dst[0] = 3;
        hi = 0; tp = 0;
        cyc(1'b0, 1'b1, 4'h1, 4'h0);
        if (in_gnt[0]) hi++;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 4'h0, 4'h0);
            if (in_gnt[0]) hi++;
            if (timeout[0]) tp++;
        end
        check("wd_hold", 32'(hi), 32'd8);
        check("wd_pulse", 32'(tp), 32'd1);
        check("wd_out3", 32'(out_vld[3]), 32'd0);

        // Watchdog with release exactly at the terminal cycle: no timeout
        hi = 0; tp = 0;
        cyc(1'b0, 1'b1, 4'h1, 4'h0);
        if (in_gnt[0]) hi++;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 4'h0, (k == 8) ? 4'h1 : 4'h0);
            if (in_gnt[0]) hi++;
            if (timeout[0]) tp++;
        end
        check("wdrel_hold", 32'(hi), 32'd8);
        check("wdrel_pulse", 32'(tp), 32'd0);

        // Enable gating
        cur_dst[3] = 0;
        cyc(1'b0, 1'b1, 4'h8, 4'h0);
        for (int i = 0; i < N; i++) cur_dst[i] = i;
        p_before = m_prio;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 4'hF, 4'h0);
        check("en_gnt", 32'(in_gnt), 32'h8);
        check("en_prio", 32'(prio_diag), 32'(p_before));
        cyc(1'b0, 1'b0, 4'hF, 4'h8);
        check("en_rel_vld", 32'(out_vld), 32'h0);
        cyc(1'b0, 1'b1, 4'hF, 4'h0);
        check("en_resume", 32'(in_gnt), 32'hF);
        cyc(1'b0, 1'b1, 4'h0, 4'hF);

        // Short random phase against the model
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < N; i++) cur_dst[i] = $urandom_range(3, 0);
            cyc(1'b0, ($urandom_range(3, 0) != 0), 4'($urandom), 4'($urandom) & 4'($urandom));
        end

        // Reset in the middle of connections clears everything, no timeout pulse
        cyc(1'b1, 1'b1, 4'hF, 4'h0);
        check("mid_rst_gnt", 32'(in_gnt), 32'd0);
        check("mid_rst_to", 32'(timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
